seq_det_ctrl: RTL and testbench
===============================

// Module: seq_det_ctrl
// PURPOSE
//  Controller that configures and sequences serial bit-pattern detection. Software/upstream
//  loads a pattern + length + overlap mode, then launches a frame of N serial bits; the block
//  gates the bit stream through a shared match core, pulses `out` per detection, counts matches,
//  and signals done. Sits between the stimulus/bit source and the detection datapath.
// PARAMETERS
//  PAT_W  8   max pattern length in bits
//  CNT_W  16  width of frame length and match counter
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  cfg_wr       in   1      load cfg_* (accepted only in IDLE)
//  cfg_pattern  in   PAT_W  pattern; bit [len-1] is the first bit received
//  cfg_len      in   LEN_W  pattern length, legal 1..PAT_W (LEN_W = clog2(PAT_W+1))
//  cfg_overlap  in   1      1 = overlapping matches, 0 = history cleared after each match
//  start        in   1      launch frame (accepted only in IDLE)
//  frame_len    in   CNT_W  bits in frame, sampled on start
//  in_valid     in   1      serial bit valid
//  in           in   1      serial data bit
//  in_ready     out  1      high only in RUN; beat = in_valid & in_ready
//  busy         out  1      state != IDLE
//  out          out  1      registered 1-cycle match pulse
//  match_count  out  CNT_W  matches in current/last frame, saturating
//  done         out  1      1-cycle pulse at frame end
//  err          out  1      1-cycle pulse with done on illegal launch
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; cfg pattern=0, len=0 (invalid), overlap=0; history cleared.
//  - FSM: IDLE -> RUN on start with valid cfg & frame_len!=0; IDLE -> DONE on start with
//    cfg_len==0, cfg_len>PAT_W or frame_len==0 (err=1, no beats taken); RUN -> DONE the cycle
//    after the frame_len-th beat; DONE -> IDLE unconditionally (done high exactly 1 cycle).
//  - start in IDLE clears history, bits_seen, beat counter, match_count in the same edge.
//  - cfg_wr and start outside IDLE are ignored; cfg_wr and start together in IDLE: cfg applied
//    first, launch uses new cfg.
//  - Per beat: hist <= {hist[PAT_W-2:0], in}; bits_seen increments, saturates at PAT_W.
//    Hit = (bits_seen incl. this bit >= len) & (new hist[len-1:0] == pattern[len-1:0]).
//  - Hit -> out=1 on the next cycle (latency 1), match_count +1 saturating at 2^CNT_W-1.
//    Non-overlap: hit also clears hist and bits_seen.
//  - Last beat at cycle t: its out pulse, final match_count and done all appear at t+1.
//  - No beat (in_valid=0) leaves history/counters unchanged; gaps are transparent.
//  - match_count holds after DONE until the next accepted start.
//  - rst mid-RUN: next cycle IDLE, outputs 0, cfg back to reset values.
// STRUCTURE
//  - Shared package seq_ctrl_pkg: FSM state encodings (IDLE, RUN, DONE), LEN_W derivation.
//  - Sub-module seq_match_core: history shift reg, bits_seen, masked compare, hit, clear.
//  - Top: FSM, cfg registers, beat/frame counter, match counter, output regs.
// TESTING
//  1 Reset: hold rst 2 cycles -> out, done, err, busy, in_ready = 0, match_count = 0.
//  2 cfg pattern=8'h0B len=4 overlap=1, frame_len=7, bits 1,0,1,1,0,1,1 back-to-back
//    -> out pulses 1 cycle after beats 4 and 7; match_count=2; done at beat7+1.
//  3 Same stream, overlap=0 -> single out pulse after beat 4; match_count=1.
//  4 Repeat test 2 with in_valid low on random cycles -> identical pulses per beat, count=2.
//  5 start right after reset (len=0) -> next cycle done=1, err=1, busy=0 after, count=0.
//  6 rst at beat 3 of test 2 -> next cycle all outputs 0, IDLE; cfg_wr during RUN is ignored
//    (count still 2 with original pattern).

Source files
------------

// File: rtl/seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_ctrl_pkg
// Description : Shared state encodings and width helpers for the sequence
//               detection controller and its match core.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_ctrl_pkg;

    localparam int c_ST_W = 2;

    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_RUN  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_DONE = 2'd2;

    // Width able to hold every legal pattern length 0..pat_w.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_core
// Description : Serial history shift register with masked pattern compare.
//               hit is combinational for the beat presented this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_core
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = len_width(8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             beat,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             hit
);

    logic [PAT_W-1:0] r_hist;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] r_seen;
    logic [LEN_W-1:0] w_seen_nxt;

    assign w_hist_nxt = {r_hist[PAT_W-2:0], bit_in};
    assign w_seen_nxt = (r_seen == LEN_W'(PAT_W)) ? r_seen : r_seen + 1'b1;

    // Only the low len bits of the history take part in the compare.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign w_mask[gi] = (32'(len) > gi);
    end

    assign hit = beat && (w_seen_nxt >= len) &&
                 (((w_hist_nxt ^ pattern) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_hist <= '0;
            r_seen <= '0;
        end else if (beat) begin
            if (hit && !overlap) begin
                r_hist <= '0;
                r_seen <= '0;
            end else begin
                r_hist <= w_hist_nxt;
                r_seen <= w_seen_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_ctrl
// Description : Configures and sequences serial pattern detection over a
//               frame of N bits; pulses out per match, counts, flags done.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 16,
    localparam int LEN_W = len_width(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic [CNT_W-1:0] frame_len,
    input  logic             in_valid,
    input  logic             in,
    output logic             in_ready,
    output logic             busy,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             err
);

    logic [c_ST_W-1:0] r_state;
    logic [PAT_W-1:0]  r_pattern;
    logic [LEN_W-1:0]  r_len;
    logic              r_overlap;
    logic [CNT_W-1:0]  r_beats;
    logic [CNT_W-1:0]  r_frame_len;
    logic [CNT_W-1:0]  r_count;
    logic              r_out;
    logic              r_done;
    logic              r_err;

    logic              w_idle;
    logic              w_launch;
    logic              w_cfg_load;
    logic [LEN_W-1:0]  w_len;
    logic              w_len_ok;
    logic              w_beat;
    logic              w_hit;
    logic [CNT_W-1:0]  w_beats_nxt;

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_launch    = w_idle && start;
    assign w_cfg_load  = w_idle && cfg_wr;
    // A simultaneous cfg_wr takes effect before the launch legality check.
    assign w_len       = w_cfg_load ? cfg_len : r_len;
    assign w_len_ok    = (w_len != '0) && (w_len <= LEN_W'(PAT_W));
    assign w_beat      = in_valid && in_ready;
    assign w_beats_nxt = r_beats + 1'b1;

    assign in_ready    = (r_state == c_ST_RUN);
    assign busy        = !w_idle;
    assign out         = r_out;
    assign done        = r_done;
    assign err         = r_err;
    assign match_count = r_count;

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_launch),
        .beat    (w_beat),
        .bit_in  (in),
        .pattern (r_pattern),
        .len     (r_len),
        .overlap (r_overlap),
        .hit     (w_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_pattern   <= '0;
            r_len       <= '0;
            r_overlap   <= 1'b0;
            r_beats     <= '0;
            r_frame_len <= '0;
            r_count     <= '0;
            r_out       <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out  <= w_hit;
            r_done <= 1'b0;
            r_err  <= 1'b0;

            if (w_hit && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end

            if (w_cfg_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_count     <= '0;
                        r_beats     <= '0;
                        r_frame_len <= frame_len;
                        if (w_len_ok && (frame_len != '0)) begin
                            r_state <= c_ST_RUN;
                        end else begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_ST_RUN: begin
                    if (w_beat) begin
                        r_beats <= w_beats_nxt;
                        if (w_beats_nxt == r_frame_len) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_ctrl
// Description : Directed, table-driven bench for seq_det_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 16;
    localparam int LEN_W = 4;

    typedef struct {
        logic        valid;
        logic        din;
        logic        exp_out;
        logic        exp_done;
        logic [15:0] exp_cnt;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             cfg_wr;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             start;
    logic [CNT_W-1:0] frame_len;
    logic             in_valid;
    logic             in;
    logic             in_ready;
    logic             busy;
    logic             out;
    logic [CNT_W-1:0] match_count;
    logic             done;
    logic             err;

    int   n_vec;
    int   n_err;
    vec_t tbl [0:24];

    seq_det_ctrl #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .start       (start),
        .frame_len   (frame_len),
        .in_valid    (in_valid),
        .in          (in),
        .in_ready    (in_ready),
        .busy        (busy),
        .out         (out),
        .match_count (match_count),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        cfg_wr      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        tick();
        cfg_wr      = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] flen);
        start     = 1'b1;
        frame_len = flen;
        tick();
        start     = 1'b0;
        chk("launch_busy", 32'(busy), 32'd1);
    endtask

    task automatic set_vec(input int i, input logic v, input logic d, input logic eo,
                           input logic ed, input logic [15:0] ec);
        tbl[i].valid    = v;
        tbl[i].din      = d;
        tbl[i].exp_out  = eo;
        tbl[i].exp_done = ed;
        tbl[i].exp_cnt  = ec;
    endtask

    task automatic run_vecs(input int lo, input int hi, input string tag);
        logic [15:0] last_cnt;
        last_cnt = 16'd0;
        for (int i = lo; i <= hi; i++) begin
            in_valid = tbl[i].valid;
            in       = tbl[i].din;
            tick();
            chk({tag, "_out"},  32'(out),         32'(tbl[i].exp_out));
            chk({tag, "_done"}, 32'(done),        32'(tbl[i].exp_done));
            chk({tag, "_cnt"},  32'(match_count), 32'(tbl[i].exp_cnt));
            chk({tag, "_err"},  32'(err),         32'd0);
            last_cnt = tbl[i].exp_cnt;
        end
        in_valid = 1'b0;
        in       = 1'b0;
        tick();
        chk({tag, "_post_done"}, 32'(done),        32'd0);
        chk({tag, "_post_busy"}, 32'(busy),        32'd0);
        chk({tag, "_hold_cnt"},  32'(match_count), 32'(last_cnt));
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        cfg_wr      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        start       = 1'b0;
        frame_len   = '0;
        in_valid    = 1'b0;
        in          = 1'b0;

        // Overlapping 1011 over 1,0,1,1,0,1,1: hits on beats 4 and 7.
        set_vec(0, 1, 1, 0, 0, 16'd0);
        set_vec(1, 1, 0, 0, 0, 16'd0);
        set_vec(2, 1, 1, 0, 0, 16'd0);
        set_vec(3, 1, 1, 1, 0, 16'd1);
        set_vec(4, 1, 0, 0, 0, 16'd1);
        set_vec(5, 1, 1, 0, 0, 16'd1);
        set_vec(6, 1, 1, 1, 1, 16'd2);
        // Non-overlapping: history cleared after beat 4, tail too short.
        set_vec(7,  1, 1, 0, 0, 16'd0);
        set_vec(8,  1, 0, 0, 0, 16'd0);
        set_vec(9,  1, 1, 0, 0, 16'd0);
        set_vec(10, 1, 1, 1, 0, 16'd1);
        set_vec(11, 1, 0, 0, 0, 16'd1);
        set_vec(12, 1, 1, 0, 0, 16'd1);
        set_vec(13, 1, 1, 0, 1, 16'd1);
        // Overlapping stream with idle gaps interleaved.
        set_vec(14, 1, 1, 0, 0, 16'd0);
        set_vec(15, 0, 0, 0, 0, 16'd0);
        set_vec(16, 1, 0, 0, 0, 16'd0);
        set_vec(17, 1, 1, 0, 0, 16'd0);
        set_vec(18, 0, 1, 0, 0, 16'd0);
        set_vec(19, 0, 0, 0, 0, 16'd0);
        set_vec(20, 1, 1, 1, 0, 16'd1);
        set_vec(21, 1, 0, 0, 0, 16'd1);
        set_vec(22, 0, 1, 0, 0, 16'd1);
        set_vec(23, 1, 1, 0, 0, 16'd1);
        set_vec(24, 1, 1, 1, 1, 16'd2);

        // Reset state
        tick();
        tick();
        chk("rst_out",      32'(out),         32'd0);
        chk("rst_done",     32'(done),        32'd0);
        chk("rst_err",      32'(err),         32'd0);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_in_ready", 32'(in_ready),    32'd0);
        chk("rst_cnt",      32'(match_count), 32'd0);
        rst = 1'b0;

        // Launch with the reset-time len of 0 is illegal
        start     = 1'b1;
        frame_len = 16'd5;
        tick();
        start = 1'b0;
        chk("bad_done",     32'(done),        32'd1);
        chk("bad_err",      32'(err),         32'd1);
        chk("bad_in_ready", 32'(in_ready),    32'd0);
        chk("bad_cnt",      32'(match_count), 32'd0);
        tick();
        chk("bad_busy_after", 32'(busy), 32'd0);
        chk("bad_err_after",  32'(err),  32'd0);
        chk("bad_done_after", 32'(done), 32'd0);

        // Overlapping detection
        do_cfg(8'h0B, 4'd4, 1'b1);
        do_start(16'd7);
        run_vecs(0, 6, "ovl");

        // Non-overlapping detection
        do_cfg(8'h0B, 4'd4, 1'b0);
        do_start(16'd7);
        run_vecs(7, 13, "novl");

        // Gaps are transparent
        do_cfg(8'h0B, 4'd4, 1'b1);
        do_start(16'd7);
        run_vecs(14, 24, "gap");

        // Reset in the middle of a run
        do_start(16'd7);
        in_valid = 1'b1;
        in       = 1'b1;
        tick();
        in = 1'b0;
        tick();
        in  = 1'b1;
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_out",      32'(out),         32'd0);
        chk("mid_rst_busy",     32'(busy),        32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),    32'd0);
        chk("mid_rst_done",     32'(done),        32'd0);
        chk("mid_rst_cnt",      32'(match_count), 32'd0);

        // cfg_wr during RUN must not disturb the active pattern
        do_cfg(8'h0B, 4'd4, 1'b1);
        do_start(16'd7);
        cfg_wr      = 1'b1;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd1;
        cfg_overlap = 1'b1;
        run_vecs(0, 6, "cfg_ign");
        cfg_wr = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
